// File: rtl/behav_16_adder_pkg.sv
// Shared widths, flag payload and flag bit positions for the adder/ALU flag path.
package behav_16_adder_pkg;

   localparam int unsigned ADD_WIDTH = 16;

   localparam int unsigned FLAG_SIGN_IDX     = 4;
   localparam int unsigned FLAG_ZERO_IDX     = 3;
   localparam int unsigned FLAG_CARRY_IDX    = 2;
   localparam int unsigned FLAG_PARITY_IDX   = 1;
   localparam int unsigned FLAG_OVERFLOW_IDX = 0;
   localparam int unsigned FLAG_COUNT        = 5;

   typedef struct packed {
      logic sign;
      logic zero;
      logic carry;
      logic parity;
      logic overflow;
   } flags_t;

endpackage

// File: rtl/adder_flag_gen.sv
// Combinational status-flag generator for a WIDTH-bit add with carry-out.
module adder_flag_gen
   import behav_16_adder_pkg::*;
#(
   parameter int unsigned WIDTH = ADD_WIDTH
) (
   input  logic           a_msb,
   input  logic           b_msb,
   input  logic [WIDTH:0] sum,
   output flags_t         flags
);

   localparam int unsigned MSB = WIDTH - 1;

   logic [WIDTH-1:0] res;

   assign res = sum[WIDTH-1:0];

   always_comb begin
      flags          = '0;
      flags.sign     = res[MSB];
      flags.zero     = (res == '0);
      flags.carry    = sum[WIDTH];
      flags.parity   = ~^res;
      // Operands share a sign that the result does not.
      flags.overflow = (a_msb & b_msb & ~res[MSB]) | (~a_msb & ~b_msb & res[MSB]);
   end

endmodule

// File: rtl/behav_16_adder.sv
// Registered WIDTH-bit adder with sign/zero/carry/parity/overflow flags, one-cycle latency.
module behav_16_adder
   import behav_16_adder_pkg::*;
#(
   parameter int unsigned WIDTH = ADD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic             sign,
   output logic             zero,
   output logic             carry,
   output logic             parity,
   output logic             overflow
);

   localparam int unsigned SUM_W = WIDTH + 1;

   logic [WIDTH:0]   sum_c;
   logic [WIDTH-1:0] c_d, c_q;
   flags_t           flags_c;
   flags_t           flags_d, flags_q;

   always_comb begin
      sum_c = SUM_W'(a) + SUM_W'(b);
   end

   adder_flag_gen #(
      .WIDTH (WIDTH)
   ) u_flag_gen (
      .a_msb (a[WIDTH-1]),
      .b_msb (b[WIDTH-1]),
      .sum   (sum_c),
      .flags (flags_c)
   );

   always_comb begin
      c_d     = sum_c[WIDTH-1:0];
      flags_d = flags_c;
   end

   // Sum and flags are captured together so they always describe the same operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q     <= '0;
         flags_q <= '0;
      end else begin
         c_q     <= c_d;
         flags_q <= flags_d;
      end
   end

   assign c        = c_q;
   assign sign     = flags_q.sign;
   assign zero     = flags_q.zero;
   assign carry    = flags_q.carry;
   assign parity   = flags_q.parity;
   assign overflow = flags_q.overflow;

endmodule

// File: tb/tb_behav_16_adder.sv
// Self-checking bench for behav_16_adder: directed corners, async reset and random streaming.
module tb_behav_16_adder;
   import behav_16_adder_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [15:0] a, b;
   logic [15:0] c;
   logic        sign, zero, carry, parity, overflow;

   int n_tests;
   int n_fail;

   behav_16_adder #(.WIDTH(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .c        (c),
      .sign     (sign),
      .zero     (zero),
      .carry    (carry),
      .parity   (parity),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference computed with integer arithmetic on the operand values.
   task automatic model(input logic [15:0] ma, input logic [15:0] mb,
                        output logic [15:0] ec, output flags_t ef);
      int unsigned us;
      int          ss;
      us = int'(ma) + int'(mb);
      ss = int'($signed(ma)) + int'($signed(mb));
      ec = 16'(us);
      ef.carry    = (us > 32'd65535);
      ef.overflow = (ss > 32767) || (ss < -32768);
      ef.sign     = (ec >= 16'h8000);
      ef.zero     = (ec == 16'h0000);
      ef.parity   = (($countones(ec) % 2) == 0);
   endtask

   task automatic check_all(input string tag, input logic [15:0] ec, input flags_t ef);
      check_val({tag, ".c"},        32'(c),        32'(ec));
      check_val({tag, ".sign"},     32'(sign),     32'(ef.sign));
      check_val({tag, ".zero"},     32'(zero),     32'(ef.zero));
      check_val({tag, ".carry"},    32'(carry),    32'(ef.carry));
      check_val({tag, ".parity"},   32'(parity),   32'(ef.parity));
      check_val({tag, ".overflow"}, 32'(overflow), 32'(ef.overflow));
   endtask

   task automatic check_lit(input string tag, input logic [15:0] ec,
                            input logic es, input logic ez, input logic ecy,
                            input logic ep, input logic eo);
      flags_t ef;
      ef.sign = es; ef.zero = ez; ef.carry = ecy; ef.parity = ep; ef.overflow = eo;
      check_all(tag, ec, ef);
   endtask

   task automatic apply(input logic [15:0] va, input logic [15:0] vb);
      @(negedge clk);
      a = va;
      b = vb;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] ec;
      flags_t      ef;
      logic [15:0] ra, rb;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      a       = 16'h0;
      b       = 16'h0;

      #3;
      check_lit("reset_init", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Release reset, then pulse it between edges to check the async clear.
      a = 16'h1234;
      b = 16'h4321;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_lit("pre_reset", 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      check_lit("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_lit("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_lit("post_reset", 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      apply(16'h8fff, 16'h8000);
      check_lit("carry_ovf", 16'h0fff, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      apply(16'h6ffe, 16'h0002);
      check_lit("plain", 16'h7000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      apply(16'h7fff, 16'h0001);
      check_lit("pos_ovf", 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      apply(16'haaaa, 16'h5555);
      check_lit("all_ones", 16'hffff, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      apply(16'hffff, 16'h0001);
      check_lit("wrap_zero", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      apply(16'h0000, 16'h0000);
      check_lit("zero_zero", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      apply(16'h8000, 16'h8000);
      check_lit("min_min", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

      // Streaming: new operands every cycle, result checked after each edge.
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 50 == 0) rb = 16'(16'h0000 - ra);
         apply(ra, rb);
         model(ra, rb, ec, ef);
         check_all("stream", ec, ef);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/behav_16_adder.md
Name: behav_16_adder

Overview:
- Registered 16-bit two's-complement/unsigned adder that produces a 16-bit sum and five status flags: sign, zero, carry, parity and overflow.
- Operands are sampled every clock; results and flags appear one cycle later.
- Serves as the arithmetic/flag core of a small ALU datapath; no handshake.

Parameters:
- WIDTH, 16, operand and sum width in bits. Flags are defined for any WIDTH ≥ 2; the default of 16 is the supported configuration.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  output  WIDTH  registered sum, a+b modulo 2^WIDTH.
- sign  output  1  registered c[WIDTH-1].
- zero  output  1  registered: 1 when c == 0.
- carry  output  1  registered unsigned carry-out, bit WIDTH of a+b.
- parity  output  1  registered even-parity flag: 1 when c has an even number of 1 bits, i.e. XNOR-reduce of c.
- overflow  output  1  registered signed overflow.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset:
  - rst_n low clears c, sign, zero, carry, parity and overflow to 0 immediately, independent of clk.
  - The registers hold 0 while rst_n is low.
  - Assertion mid-operation discards the in-flight result.
- First edge after reset: the first rising edge of clk after rst_n deasserts captures the current a/b.
- Latency:
  - Exactly 1 cycle. The values of a/b sampled at rising edge N appear on all outputs after edge N, and remain stable until edge N+1.
  - Throughput is one addition per cycle.
  - There is no enable; the registers load every cycle.
- Arithmetic:
  - Form a WIDTH+1-bit sum {carry, c} = a + b with zero-extended operands. There is no carry-in.
- Overflow:
  - overflow = (a[MSB] & b[MSB] & ~c[MSB]) | (~a[MSB] & ~b[MSB] & c[MSB]), using the unregistered sum.
  - It is therefore set only when both operands have the same sign and the result's sign differs.
- Flag consistency: all flags are computed combinationally from the same-cycle a, b and sum, and registered together with c. Flags never mix operands from different cycles.
- Boundary conditions:
  - all-ones + 1 wraps to 0, with carry=1 and zero=1.
  - 0+0 gives zero=1, parity=1, carry=0.
  - Most-negative + most-negative gives c=0, carry=1, overflow=1.
- Unknowns: X/Z on a or b must not be masked. Outputs follow normal 4-state propagation; no special handling is required.

Decomposition:
- Shared package holds:
  - WIDTH default (16).
  - A flags struct typedef, {sign, zero, carry, parity, overflow}, for use by downstream ALU/flag-register blocks.
  - Flag bit-index constants.
- One natural combinational sub-module, adder_flag_gen:
  - Inputs: a, b and the WIDTH+1-bit sum.
  - Outputs: the five flags.
  - The top level instantiates it and holds only the adder expression plus the output register stage.

Test Plan:
- Reset: drive a=1234, b=4321, then pulse rst_n low between edges -> all outputs read 0 immediately. After release and one edge, c=5555, sign=0, zero=0, carry=0, parity=1, overflow=0.
- Carry plus signed overflow: a=8fff, b=8000 -> one cycle later c=0fff, carry=1, overflow=1, sign=0, zero=0, parity=1.
- Plain add: a=6ffe, b=0002 -> c=7000, all flags 0 except none (sign=0, zero=0, carry=0, parity=0, overflow=0). Then a=7fff, b=0001 -> c=8000, sign=1, overflow=1, carry=0, parity=0.
- No-carry all-ones: a=aaaa, b=5555 -> c=ffff, sign=1, parity=1, carry=0, zero=0, overflow=0.
- Wrap to zero: a=ffff, b=0001 -> c=0000, carry=1, zero=1, parity=1, sign=0, overflow=0. Then a=0000, b=0000 -> c=0000, zero=1, parity=1, carry=0.
- Back-to-back streaming: change a/b on every cycle over 1000 random vectors -> each output cycle matches a golden model applied to the inputs of the previous edge, with no bubbles.
